rr_grant_sched: RTL

- Round-robin arbiter sharing one resource (DMA channel, register bus, or similar) among N requesters.
- Request vector is masked by the pointer, and the next owner is picked with a count-trailing-zeros priority encoder.
- Grant is registered and held until the owner releases it, drops its request, or exceeds a hold limit.
- Sits between per-channel request logic and the shared resource mux; gnt_idx_o drives the mux select.

---
 rtl/rr_grant_sched_pkg.sv | 14 +
 rtl/rr_grant_sched_ctz.sv | 34 +++
 rtl/rr_grant_sched.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rr_grant_sched_pkg.sv
// Shared definitions for the round-robin grant scheduler.
//   state_e : arbiter state encoding
//   CNT_W   : width of the grant-length counter
package rr_grant_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    localparam int CNT_W = 16;

endpackage

// File: rtl/rr_grant_sched_ctz.sv
// Priority encoder counting trailing (CLZ=0) or leading (CLZ=1) zeros.
//   in_i   : vector to encode
//   cnt_o  : zero count; 0 (ZERO_IF_NONE=1) or all-ones when in_i is zero
//   zero_o : in_i has no bit set
module rr_grant_sched_ctz #(
    parameter int BITS         = 8,
    parameter int CLZ          = 0,
    parameter int ZERO_IF_NONE = 1
) (
    input  logic [BITS-1:0]         in_i,
    output logic [$clog2(BITS)-1:0] cnt_o,
    output logic                    zero_o
);

    localparam int W = $clog2(BITS);

    always_comb begin
        cnt_o  = '0;
        zero_o = (in_i == '0);
        if (CLZ != 0) begin
            // Ascending scan: the highest set bit is assigned last and wins.
            for (int i = 0; i < BITS; i++) begin
                if (in_i[i]) cnt_o = W'(BITS - 1 - i);
            end
        end else begin
            // Descending scan: the lowest set bit is assigned last and wins.
            for (int i = BITS - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = W'(i);
            end
        end
        if (zero_o && (ZERO_IF_NONE == 0)) cnt_o = '1;
    end

endmodule

// File: rtl/rr_grant_sched.sv
// Round-robin arbiter for one shared resource among N requesters.
//   clk, rst     : clock, asynchronous active-high reset
//   req_i, en_i  : level requests and per-requester enables
//   done_i       : owner release pulse (only honoured while a grant is active)
//   gnt_o        : one-hot grant, zero when idle
//   gnt_idx_o    : owner index, holds the last owner when idle (resource mux select)
//   gnt_valid_o  : grant active
//   timeout_o    : one-cycle pulse when the hold limit forced the release
//   busy_cnt_o   : cycles elapsed in the current grant (saturating)
module rr_grant_sched
    import rr_grant_sched_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOG_N    = $clog2(N),
    parameter int HOLD_MAX = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     en_i,
    input  logic             done_i,
    output logic [N-1:0]     gnt_o,
    output logic [LOG_N-1:0] gnt_idx_o,
    output logic             gnt_valid_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] busy_cnt_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_e             state_q;
    logic [LOG_N-1:0]   last_q;
    logic [LOG_N-1:0]   gnt_idx_q;
    logic [N-1:0]       gnt_q;
    logic               gnt_valid_q;
    logic               timeout_q;
    logic [CNT_W-1:0]   busy_cnt_q;
    logic [CNT_W-1:0]   busy_cnt_d;

    logic [N-1:0]       eff;
    logic [N-1:0]       hi;
    logic [N:0]         low_mask;
    logic [LOG_N-1:0]   hi_idx;
    logic [LOG_N-1:0]   eff_idx;
    logic [LOG_N-1:0]   winner;
    logic               hi_zero;
    logic               eff_zero;
    logic               own_req;
    logic               own_en;
    logic               hold_hit;
    logic               rel;

    assign eff = req_i & en_i;

    // Bits 0..last set; one bit wider so last=N-1 yields an all-ones mask
    // (no requester above the pointer) without overflow.
    assign low_mask = ((N + 1)'(2) << last_q) - (N + 1)'(1);
    assign hi       = eff & ~low_mask[N-1:0];

    rr_grant_sched_ctz #(.BITS(N), .CLZ(0), .ZERO_IF_NONE(1)) u_ctz_hi (
        .in_i   (hi),
        .cnt_o  (hi_idx),
        .zero_o (hi_zero)
    );

    rr_grant_sched_ctz #(.BITS(N), .CLZ(0), .ZERO_IF_NONE(1)) u_ctz_eff (
        .in_i   (eff),
        .cnt_o  (eff_idx),
        .zero_o (eff_zero)
    );

    // Wrap around to the full vector only when nobody above the pointer asks.
    assign winner = hi_zero ? eff_idx : hi_idx;

    assign own_req  = req_i[gnt_idx_q];
    assign own_en   = en_i[gnt_idx_q];
    assign hold_hit = (HOLD_MAX != 0) && (busy_cnt_q == HOLD_LAST);
    assign rel      = done_i || !own_req || !own_en || hold_hit;

    assign busy_cnt_d = (busy_cnt_q == '1) ? busy_cnt_q : busy_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= LOG_N'(N - 1);
            gnt_idx_q   <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_cnt_q  <= '0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    busy_cnt_q <= '0;
                    if (!eff_zero) begin
                        gnt_q       <= N'(1) << winner;
                        gnt_idx_q   <= winner;
                        gnt_valid_q <= 1'b1;
                        last_q      <= winner;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (rel) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        busy_cnt_q  <= '0;
                        // Timeout only when the limit alone forced the release.
                        timeout_q   <= hold_hit && !done_i && own_req && own_en;
                        state_q     <= ST_RELEASE;
                    end else begin
                        busy_cnt_q <= busy_cnt_d;
                    end
                end
                ST_RELEASE: begin
                    busy_cnt_q <= '0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    gnt_q       <= '0;
                    gnt_valid_q <= 1'b0;
                    busy_cnt_q  <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = gnt_valid_q;
    assign timeout_o   = timeout_q;
    assign busy_cnt_o  = busy_cnt_q;

endmodule
